// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron layer: config select codes,
// controller state encoding and a saturating adder.
package lif_pkg;

  // cfg_sel codes
  localparam logic [2:0] CFG_INPUT  = 3'b000;
  localparam logic [2:0] CFG_WEIGHT = 3'b001;
  localparam logic [2:0] CFG_THRESH = 3'b010;
  localparam logic [2:0] CFG_LEAK   = 3'b011;
  localparam logic [2:0] CFG_REFR   = 3'b100;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed add clamped to the range of a 'width'-bit two's complement value.
  function automatic int sat_add(input int a, input int b, input int width);
    int s;
    int hi;
    int lo;
    s  = a + b;
    hi = (1 << (width - 1)) - 1;
    lo = -(1 << (width - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/lif_neuron_array_core.sv
// Combinational update of one LIF neuron: +/-1 synaptic sum, leak,
// saturating integration and threshold test with subtractive reset.
module lif_neuron_core
  import lif_pkg::*;
#(
  parameter int N_INPUTS       = 32,
  parameter int MEMBRANE_BITS  = 8,
  parameter int THRESHOLD_BITS = 7
) (
  input  logic [N_INPUTS-1:0]             in_vec,
  input  logic [N_INPUTS-1:0]             weights,
  input  logic signed [MEMBRANE_BITS-1:0] membrane,
  input  logic [THRESHOLD_BITS-1:0]       threshold,
  input  logic [2:0]                      leak_shift,
  output logic signed [MEMBRANE_BITS-1:0] next_membrane,
  output logic                            spike
);

  localparam int SUM_BITS = $clog2(N_INPUTS) + 2;

  logic signed [SUM_BITS-1:0]      pos_count;
  logic signed [SUM_BITS-1:0]      neg_count;
  logic signed [SUM_BITS-1:0]      sum;
  logic signed [MEMBRANE_BITS-1:0] leaked;
  int                              nxt;
  int                              thr;

  // Excitatory minus inhibitory active inputs, then leak, integrate and fire
  always_comb begin
    pos_count     = '0;
    neg_count     = '0;
    sum           = '0;
    leaked        = membrane;
    nxt           = 0;
    thr           = 0;
    spike         = 1'b0;
    next_membrane = membrane;
    for (int i = 0; i < N_INPUTS; i++) begin
      pos_count = pos_count + SUM_BITS'(in_vec[i] & weights[i]);
      neg_count = neg_count + SUM_BITS'(in_vec[i] & ~weights[i]);
    end
    sum = pos_count - neg_count;
    // m - (m >>> s) cannot overflow, so the leak needs no widening
    if (leak_shift != 3'd0) begin
      leaked = membrane - (membrane >>> leak_shift);
    end
    nxt = sat_add(int'(leaked), int'(sum), MEMBRANE_BITS);
    thr = int'(threshold);
    if (nxt >= thr) begin
      spike         = 1'b1;
      next_membrane = MEMBRANE_BITS'(nxt - thr);
    end else begin
      next_membrane = MEMBRANE_BITS'(nxt);
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Layer of LIF neurons sharing one input vector, evaluated one neuron per
// cycle through a single shared core. Configuration arrives byte-wise.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N_INPUTS        = 32,
  parameter int N_NEURONS       = 4,
  parameter int MEMBRANE_BITS   = 8,
  parameter int THRESHOLD_BITS  = 7,
  parameter int REFRACTORY_BITS = 3,
  localparam int NB             = $clog2(N_NEURONS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cfg_we,
  input  logic [2:0]                      cfg_sel,
  input  logic [NB-1:0]                   cfg_neuron,
  input  logic [7:0]                      cfg_data,
  input  logic                            step,
  output logic                            busy,
  output logic                            done,
  output logic [N_NEURONS-1:0]            spikes,
  input  logic [NB-1:0]                   membrane_sel,
  output logic signed [MEMBRANE_BITS-1:0] membrane_out
);

  localparam logic [NB-1:0] LAST = NB'(N_NEURONS - 1);

  state_t                            state;
  logic [NB-1:0]                     idx;
  logic [N_INPUTS-1:0]               in_vec;
  logic [N_INPUTS-1:0]               weights   [N_NEURONS];
  logic [THRESHOLD_BITS-1:0]         threshold [N_NEURONS];
  logic signed [MEMBRANE_BITS-1:0]   membrane  [N_NEURONS];
  logic [REFRACTORY_BITS-1:0]        refr      [N_NEURONS];
  logic [2:0]                        leak_shift;
  logic [REFRACTORY_BITS-1:0]        refr_period;
  logic [N_NEURONS-1:0]              staging;
  logic [N_NEURONS-1:0]              staging_next;

  logic signed [MEMBRANE_BITS-1:0]   core_membrane;
  logic                              core_spike;
  logic                              refractory;
  logic                              fire;

  lif_neuron_core #(
    .N_INPUTS       (N_INPUTS),
    .MEMBRANE_BITS  (MEMBRANE_BITS),
    .THRESHOLD_BITS (THRESHOLD_BITS)
  ) u_core (
    .in_vec        (in_vec),
    .weights       (weights[idx]),
    .membrane      (membrane[idx]),
    .threshold     (threshold[idx]),
    .leak_shift    (leak_shift),
    .next_membrane (core_membrane),
    .spike         (core_spike)
  );

  assign refractory   = (refr[idx] != '0);
  assign fire         = core_spike && !refractory;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign membrane_out = membrane[membrane_sel];

  // Staging vector with the current neuron's spike merged in, so the last
  // neuron's result reaches spikes on the same edge that enters DONE
  generate
    for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_stage
      assign staging_next[gi] = (idx == NB'(gi)) ? fire : staging[gi];
    end
  endgenerate

  // Controller, configuration writes and per-neuron state update
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      in_vec      <= '0;
      leak_shift  <= '0;
      refr_period <= '0;
      staging     <= '0;
      spikes      <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        weights[i]   <= '1;
        threshold[i] <= THRESHOLD_BITS'(5);
        membrane[i]  <= '0;
        refr[i]      <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (cfg_we) begin
            case (cfg_sel)
              CFG_INPUT:  in_vec <= {in_vec[N_INPUTS-9:0], cfg_data};
              CFG_WEIGHT: weights[cfg_neuron] <= {weights[cfg_neuron][N_INPUTS-9:0], cfg_data};
              CFG_THRESH: threshold[cfg_neuron] <= cfg_data[THRESHOLD_BITS-1:0];
              CFG_LEAK:   leak_shift <= cfg_data[2:0];
              CFG_REFR:   refr_period <= cfg_data[REFRACTORY_BITS-1:0];
              default: ;
            endcase
          end
          if (step) begin
            state   <= EVAL;
            idx     <= '0;
            staging <= '0;
          end
        end
        EVAL: begin
          if (refractory) begin
            refr[idx] <= refr[idx] - REFRACTORY_BITS'(1);
          end else begin
            membrane[idx] <= core_membrane;
            if (core_spike) refr[idx] <= refr_period;
          end
          staging <= staging_next;
          if (idx == LAST) begin
            state  <= DONE;
            spikes <= staging_next;
          end else begin
            idx <= idx + NB'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array: directed scenarios plus a
// randomized run, all compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_lif_neuron_array;

  localparam int N  = 4;
  localparam int NI = 32;
  localparam int NB = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_we = 1'b0;
  logic [2:0]        cfg_sel = 3'd0;
  logic [NB-1:0]     cfg_neuron = '0;
  logic [7:0]        cfg_data = 8'd0;
  logic              step = 1'b0;
  logic              busy;
  logic              done;
  logic [N-1:0]      spikes;
  logic [NB-1:0]     membrane_sel = '0;
  logic signed [7:0] membrane_out;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [NI-1:0] m_in;
  logic [NI-1:0] m_w [N];
  int            m_thr [N];
  int            m_mem [N];
  int            m_refr [N];
  int            m_ls;
  int            m_rp;
  logic [N-1:0]  m_spk;

  lif_neuron_array dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_we       (cfg_we),
    .cfg_sel      (cfg_sel),
    .cfg_neuron   (cfg_neuron),
    .cfg_data     (cfg_data),
    .step         (step),
    .busy         (busy),
    .done         (done),
    .spikes       (spikes),
    .membrane_sel (membrane_sel),
    .membrane_out (membrane_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    m_in  = '0;
    m_ls  = 0;
    m_rp  = 0;
    m_spk = '0;
    for (int k = 0; k < N; k++) begin
      m_w[k]    = '1;
      m_thr[k]  = 5;
      m_mem[k]  = 0;
      m_refr[k] = 0;
    end
  endfunction

  // One timestep of the whole layer, straight from the neuron equations
  function automatic void model_step();
    for (int k = 0; k < N; k++) begin
      int sum;
      int leaked;
      int nxt;
      if (m_refr[k] != 0) begin
        m_refr[k] = m_refr[k] - 1;
        m_spk[k]  = 1'b0;
      end else begin
        sum    = $countones(m_in & m_w[k]) - $countones(m_in & ~m_w[k]);
        leaked = (m_ls == 0) ? m_mem[k] : m_mem[k] - (m_mem[k] >>> m_ls);
        nxt    = leaked + sum;
        if (nxt > 127)  nxt = 127;
        if (nxt < -128) nxt = -128;
        if (nxt >= m_thr[k]) begin
          m_spk[k]  = 1'b1;
          m_mem[k]  = nxt - m_thr[k];
          m_refr[k] = m_rp;
        end else begin
          m_spk[k] = 1'b0;
          m_mem[k] = nxt;
        end
      end
    end
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic cfg(input logic [2:0] sel, input int n, input logic [7:0] d);
    cfg_we     = 1'b1;
    cfg_sel    = sel;
    cfg_neuron = NB'(n);
    cfg_data   = d;
    tick();
    cfg_we = 1'b0;
    case (sel)
      3'd0: m_in = {m_in[NI-9:0], d};
      3'd1: m_w[n] = {m_w[n][NI-9:0], d};
      3'd2: m_thr[n] = int'(d[6:0]);
      3'd3: m_ls = int'(d[2:0]);
      3'd4: m_rp = int'(d[2:0]);
      default: ;
    endcase
  endtask

  task automatic check_mem(input string tag, input int k, input int exp);
    membrane_sel = NB'(k);
    #1;
    check(tag, membrane_out, exp);
  endtask

  // Request a step, wait (bounded) for done, compare everything with the model
  task automatic do_step(input string tag);
    int cnt;
    step = 1'b1;
    tick();
    step = 1'b0;
    model_step();
    check({tag, "_busy"}, busy, 1);
    cnt = 0;
    while (done !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    check({tag, "_latency"}, cnt, N);
    check({tag, "_spikes"}, spikes, m_spk);
    for (int k = 0; k < N; k++) check_mem({tag, "_mem"}, k, m_mem[k]);
    tick();
    check({tag, "_idle"}, busy, 0);
    check({tag, "_spk_hold"}, spikes, m_spk);
  endtask

  initial begin
    int exp2 [5];
    int exp3 [3];
    int exp4s [4];
    int exp4m [4];
    int ndone;
    exp2  = '{-32, -64, -96, -128, -128};
    exp3  = '{1, 2, 2};
    exp4s = '{1, 0, 0, 1};
    exp4m = '{27, 27, 27, 54};

    // Reset state
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_spikes", spikes, 0);
    for (int k = 0; k < N; k++) check_mem("rst_mem", k, 0);

    // 1: all inputs active, default weights and thresholds
    for (int b = 0; b < 4; b++) cfg(3'd0, 0, 8'hFF);
    do_step("t1");
    check("t1_spikes_const", spikes, 4'b1111);
    for (int k = 0; k < N; k++) check_mem("t1_mem_const", k, 27);

    // 2: inhibitory neuron saturates at the negative rail
    do_reset();
    for (int b = 0; b < 4; b++) cfg(3'd0, 0, 8'hFF);
    for (int b = 0; b < 4; b++) cfg(3'd1, 2, 8'h00);
    for (int s = 0; s < 5; s++) begin
      do_step("t2");
      check_mem("t2_mem2", 2, exp2[s]);
      check("t2_spk2", spikes[2], 0);
    end

    // 3: leak balances a single active input below a high threshold
    do_reset();
    cfg(3'd3, 0, 8'd1);
    for (int k = 0; k < N; k++) cfg(3'd2, k, 8'd127);
    cfg(3'd0, 0, 8'h00);
    cfg(3'd0, 0, 8'h00);
    cfg(3'd0, 0, 8'h00);
    cfg(3'd0, 0, 8'h01);
    for (int s = 0; s < 3; s++) begin
      do_step("t3");
      check_mem("t3_mem0", 0, exp3[s]);
      check("t3_spikes", spikes, 0);
    end

    // 4: refractory period suppresses two steps after a spike
    do_reset();
    cfg(3'd4, 0, 8'd2);
    for (int b = 0; b < 4; b++) cfg(3'd0, 0, 8'hFF);
    for (int s = 0; s < 4; s++) begin
      do_step("t4");
      check("t4_spk0", spikes[0], exp4s[s]);
      check_mem("t4_mem0", 0, exp4m[s]);
    end

    // 5: step and config write while busy are both ignored
    do_reset();
    for (int b = 0; b < 4; b++) cfg(3'd0, 0, 8'hFF);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    step       = 1'b1;
    cfg_we     = 1'b1;
    cfg_sel    = 3'd2;
    cfg_neuron = '0;
    cfg_data   = 8'd1;
    tick();
    step   = 1'b0;
    cfg_we = 1'b0;
    model_step();
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done === 1'b1) begin
        ndone++;
        check("t5_spikes", spikes, 4'b1111);
      end
      tick();
    end
    check("t5_done_count", ndone, 1);
    for (int k = 0; k < N; k++) check_mem("t5_mem", k, 27);
    do_step("t5_after");
    check_mem("t5_thr_kept", 0, 54);

    // 6: reset during the second evaluation cycle aborts the step
    do_reset();
    for (int b = 0; b < 4; b++) cfg(3'd0, 0, 8'hFF);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_spikes", spikes, 0);
    for (int k = 0; k < N; k++) check_mem("t6_mem", k, 0);
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    check("t6_no_done", ndone, 0);

    // Randomized configuration and stepping against the model
    do_reset();
    for (int it = 0; it < 40; it++) begin
      int nw;
      nw = int'($urandom_range(0, 4));
      for (int w = 0; w < nw; w++) begin
        logic [2:0] sel;
        logic [7:0] d;
        sel = 3'($urandom_range(0, 7));
        d   = (sel == 3'd2) ? 8'($urandom_range(0, 40)) : 8'($urandom);
        cfg(sel, int'($urandom_range(0, N - 1)), d);
      end
      do_step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
